if_fetch_redirect: RTL

- IF-stage fetch unit that owns the architectural PC.
- Drives a variable-latency instruction-memory req/ack port and presents fetched instructions to the IF/ID register through a one-entry skid buffer.
- Receives the EX-stage redirect outputs (branch/jalr decision and targets) and kills wrong-path fetches, including any already in flight.
- Produces the flush pulse for the IF/ID and ID/EX registers.

---
 rtl/if_fetch_redirect.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/if_fetch_redirect.sv
// IF-stage fetch unit: owns the architectural PC, drives a variable-latency
// req/ack instruction-memory port, buffers one instruction in a skid entry
// when IF/ID stalls, and kills wrong-path fetches on an EX-stage redirect.
//
// Optional build macro: IF_PERF_CNT_EN adds fetch_cnt / redirect_cnt outputs.
module if_fetch_redirect #(
  parameter int                         INST_WIDTH      = 32,
  parameter int                         INST_ADDR_WIDTH = 32,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0,
  parameter logic [INST_WIDTH-1:0]      NOP_INST        = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       PC_take_branch_EX,
  input  logic                       PC_take_jalr_EX,
  input  logic [INST_ADDR_WIDTH-1:0] PC_for_jalr_EX,
  input  logic [INST_ADDR_WIDTH-1:0] PC_for_normal_branch_EX,
  input  logic                       stall_IF,
  output logic                       imem_req,
  output logic [INST_ADDR_WIDTH-1:0] imem_addr,
  input  logic                       imem_ack,
  input  logic [INST_WIDTH-1:0]      imem_rdata,
  output logic [INST_WIDTH-1:0]      INST_IF,
  output logic [INST_ADDR_WIDTH-1:0] PC_IF,
  output logic [INST_ADDR_WIDTH-1:0] PC_plus_4_IF,
  output logic                       valid_IF,
  output logic                       flush_IF
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]                fetch_cnt,
  output logic [31:0]                redirect_cnt
`endif
);

  localparam logic [INST_ADDR_WIDTH-1:0] PC_STEP = INST_ADDR_WIDTH'(4);

  typedef enum logic [1:0] {
    IDLE,   // one dead cycle after reset before the first request
    FETCH,  // request outstanding at pc
    FULL,   // skid entry occupied, waiting for IF/ID to drain
    KILL    // wrong-path request outstanding, its data will be dropped
  } state_t;

  state_t                       state_q, state_d;
  logic [INST_ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [INST_ADDR_WIDTH-1:0]   kill_addr_q, kill_addr_d;
  logic                         valid_q, valid_d;
  logic [INST_WIDTH-1:0]        inst_q, inst_d;
  logic [INST_ADDR_WIDTH-1:0]   pc_if_q, pc_if_d;
  logic [INST_WIDTH-1:0]        skid_inst_q, skid_inst_d;
  logic [INST_ADDR_WIDTH-1:0]   skid_pc_q, skid_pc_d;

  logic                         redirect;
  logic [INST_ADDR_WIDTH-1:0]   target_raw;
  logic [INST_ADDR_WIDTH-1:0]   target;
  logic                         slot_free;
  logic                         ack;

  // Redirect decode, memory-port drive and handshake qualification.
  always_comb begin
    redirect   = PC_take_branch_EX | PC_take_jalr_EX;
    target_raw = PC_take_jalr_EX ? PC_for_jalr_EX : PC_for_normal_branch_EX;
    target     = {target_raw[INST_ADDR_WIDTH-1:2], 2'b00};
    // The output register may load when it is empty or being drained.
    slot_free  = !valid_q || !stall_IF;
    imem_req   = (state_q == FETCH) || (state_q == KILL);
    // KILL keeps presenting the wrong-path address until its ack arrives,
    // while pc already holds the redirect target.
    imem_addr  = (state_q == KILL) ? kill_addr_q : pc_q;
    // An ack is only meaningful while a request is being driven.
    ack        = imem_ack && imem_req;
  end

  assign flush_IF     = redirect;
  assign valid_IF     = valid_q;
  assign INST_IF      = inst_q;
  assign PC_IF        = pc_if_q;
  assign PC_plus_4_IF = pc_if_q + PC_STEP;

  // Next-state and next-datapath decision; redirect overrides stall and ack.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    kill_addr_d = kill_addr_q;
    valid_d     = valid_q;
    inst_d      = inst_q;
    pc_if_d     = pc_if_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;

    if (redirect) begin
      valid_d     = 1'b0;
      inst_d      = NOP_INST;
      skid_inst_d = NOP_INST;
      skid_pc_d   = RESET_PC;
      pc_d        = target;
      unique case (state_q)
        FETCH: begin
          if (ack) begin
            state_d = FETCH;
          end else begin
            state_d     = KILL;
            kill_addr_d = pc_q;
          end
        end
        // A late ack together with a new redirect still retires the old
        // request; otherwise keep waiting with the newest target pending.
        KILL:    state_d = ack ? FETCH : KILL;
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = FETCH;
        end
        FETCH: begin
          if (ack) begin
            pc_d = pc_q + PC_STEP;
            if (slot_free) begin
              valid_d = 1'b1;
              inst_d  = imem_rdata;
              pc_if_d = pc_q;
            end else begin
              skid_inst_d = imem_rdata;
              skid_pc_d   = pc_q;
              state_d     = FULL;
            end
          end else if (slot_free) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
          end
        end
        FULL: begin
          if (!stall_IF) begin
            valid_d = 1'b1;
            inst_d  = skid_inst_q;
            pc_if_d = skid_pc_q;
            state_d = FETCH;
          end
        end
        KILL: begin
          if (ack) begin
            state_d = FETCH;
          end
          if (slot_free) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, PC, output and skid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      kill_addr_q <= RESET_PC;
      valid_q     <= 1'b0;
      inst_q      <= NOP_INST;
      pc_if_q     <= RESET_PC;
      skid_inst_q <= NOP_INST;
      skid_pc_q   <= RESET_PC;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_addr_q <= kill_addr_d;
      valid_q     <= valid_d;
      inst_q      <= inst_d;
      pc_if_q     <= pc_if_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic fetch_load;

  // A valid instruction enters the output register from memory or the skid.
  assign fetch_load = !redirect &&
                      (((state_q == FETCH) && ack && slot_free) ||
                       ((state_q == FULL) && !stall_IF));

  // Free-running, wrapping performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (fetch_load) fetch_cnt <= fetch_cnt + 32'd1;
      if (redirect)   redirect_cnt <= redirect_cnt + 32'd1;
    end
  end
`endif

endmodule
